// File: rtl/ivector_say_driver.sv
// ivector_say_driver: round-robin say() initiator and heard() in-order checker
// for the vector echo block. Tracks per-method outstanding requests and the
// expected response index, and latches the first failing indication.
module ivector_say_driver #(
  parameter int unsigned NUM_METH = 10,
  parameter int unsigned MAX_OUT  = 2,
  parameter int unsigned IDX_W    = 24
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [31:0] total,
  output logic        say__ENA,
  output logic [31:0] say_meth,
  output logic [31:0] say_v,
  input  logic        say__RDY,
  input  logic        heard__ENA,
  input  logic [31:0] heard_meth,
  input  logic [31:0] heard_v,
  output logic        heard__RDY,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] err_meth,
  output logic [31:0] sent_count,
  output logic [31:0] recv_count
);

  localparam int unsigned PTR_W = (NUM_METH > 1) ? $clog2(NUM_METH) : 1;
  localparam int unsigned OUT_W = 8;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] ptr_q;
  logic [IDX_W-1:0] send_idx_q [NUM_METH];
  logic [IDX_W-1:0] exp_idx_q  [NUM_METH];
  logic [OUT_W-1:0] outst_q    [NUM_METH];
  logic [31:0]      total_q;
  logic [31:0]      sent_q;
  logic [31:0]      recv_q;
  logic [31:0]      err_meth_q;
  logic             error_q;
  logic             rdy_q;

  logic             idle_or_done;
  logic             start_ok;
  logic             can_issue;
  logic             say_fire;
  logic             heard_fire;
  logic             hm_in_range;
  logic [PTR_W-1:0] hm;
  logic [OUT_W-1:0] hm_outst;
  logic [31:0]      hm_exp_v;
  logic             err_abc;
  logic             hm_update;
  logic             hm_fail;
  logic [PTR_W-1:0] ptr_next;

  // Handshake qualification and indication checks, all decoded from registers
  // plus the heard inputs; say__ENA never looks at say__RDY.
  always_comb begin
    idle_or_done = (state_q == S_IDLE) || (state_q == S_DONE);
    start_ok     = start && idle_or_done;
    can_issue    = (state_q == S_RUN) && (outst_q[ptr_q] < OUT_W'(MAX_OUT));
    say_fire     = can_issue && say__RDY;
    heard_fire   = heard__ENA && rdy_q;
    hm_in_range  = heard_meth < 32'(NUM_METH);
    hm           = heard_meth[PTR_W-1:0];
    hm_outst     = hm_in_range ? outst_q[hm] : '0;
    hm_exp_v     = hm_in_range ? ((32'(hm) << IDX_W) | 32'(exp_idx_q[hm])) : '0;
    err_abc      = idle_or_done || !hm_in_range || (hm_outst == '0);
    hm_update    = heard_fire && !err_abc;
    hm_fail      = heard_fire && (err_abc || (heard_v != hm_exp_v));
    ptr_next     = (ptr_q == PTR_W'(NUM_METH - 1)) ? '0 : ptr_q + PTR_W'(1);
  end

  // Next-state logic for the run sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = (total == '0) ? S_DONE : S_RUN;
      S_RUN:          if (say_fire && (sent_q + 32'd1 == total_q)) state_d = S_DRAIN;
      S_DRAIN:        if (recv_q >= total_q) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  // State register and ready flop; ready rises on the first clock after reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
    end
  end

  // Run counters, round-robin pointer and sticky error capture.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr_q      <= '0;
      total_q    <= '0;
      sent_q     <= '0;
      recv_q     <= '0;
      error_q    <= 1'b0;
      err_meth_q <= '0;
    end else if (start_ok) begin
      ptr_q      <= '0;
      total_q    <= total;
      sent_q     <= '0;
      recv_q     <= '0;
      error_q    <= 1'b0;
      err_meth_q <= '0;
    end else begin
      // A blocked method is skipped: the pointer moves on whether or not it issued.
      if ((state_q == S_RUN) && (say_fire || !can_issue)) ptr_q <= ptr_next;
      if (say_fire) sent_q <= sent_q + 32'd1;
      if (heard_fire && (recv_q != '1)) recv_q <= recv_q + 32'd1;
      if (hm_fail && !error_q) begin
        error_q    <= 1'b1;
        err_meth_q <= heard_meth;
      end
    end
  end

  // Per-method send/expect indices and outstanding counts; a simultaneous issue
  // and retire on one method leaves the outstanding count unchanged.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < NUM_METH; i++) begin
        send_idx_q[i] <= '0;
        exp_idx_q[i]  <= '0;
        outst_q[i]    <= '0;
      end
    end else if (start_ok) begin
      for (int unsigned i = 0; i < NUM_METH; i++) begin
        send_idx_q[i] <= '0;
        exp_idx_q[i]  <= '0;
        outst_q[i]    <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_METH; i++) begin
        if (say_fire && (ptr_q == PTR_W'(i)))
          send_idx_q[i] <= send_idx_q[i] + IDX_W'(1);
        if (hm_update && (hm == PTR_W'(i)))
          exp_idx_q[i] <= exp_idx_q[i] + IDX_W'(1);
        if (say_fire && (ptr_q == PTR_W'(i)) && !(hm_update && (hm == PTR_W'(i))))
          outst_q[i] <= outst_q[i] + OUT_W'(1);
        else if (hm_update && (hm == PTR_W'(i)) && !(say_fire && (ptr_q == PTR_W'(i))))
          outst_q[i] <= outst_q[i] - OUT_W'(1);
      end
    end
  end

  // Output decode; request fields are zeroed whenever no request is offered.
  always_comb begin
    say__ENA   = can_issue;
    say_meth   = can_issue ? 32'(ptr_q) : '0;
    say_v      = can_issue ? ((32'(ptr_q) << IDX_W) | 32'(send_idx_q[ptr_q])) : '0;
    heard__RDY = rdy_q;
    busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
    done       = (state_q == S_DONE);
    error      = error_q;
    err_meth   = err_meth_q;
    sent_count = sent_q;
    recv_count = recv_q;
  end

endmodule

// File: tb/tb_ivector_say_driver.sv
// Testbench for ivector_say_driver: behavioural echo model plus a say-request
// scoreboard; status outputs are checked against hand-derived values.
module tb_ivector_say_driver;

  localparam int unsigned NM = 10;
  localparam int unsigned MO = 2;
  localparam int unsigned IW = 24;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic [31:0] total;
  logic        say__ENA;
  logic [31:0] say_meth;
  logic [31:0] say_v;
  logic        say__RDY;
  logic        heard__ENA;
  logic [31:0] heard_meth;
  logic [31:0] heard_v;
  logic        heard__RDY;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] err_meth;
  logic [31:0] sent_count;
  logic [31:0] recv_count;

  always #5 CLK = ~CLK;

  ivector_say_driver #(.NUM_METH(NM), .MAX_OUT(MO), .IDX_W(IW)) dut (
    .CLK(CLK), .RST(RST), .start(start), .total(total),
    .say__ENA(say__ENA), .say_meth(say_meth), .say_v(say_v), .say__RDY(say__RDY),
    .heard__ENA(heard__ENA), .heard_meth(heard_meth), .heard_v(heard_v),
    .heard__RDY(heard__RDY), .busy(busy), .done(done), .error(error),
    .err_meth(err_meth), .sent_count(sent_count), .recv_count(recv_count)
  );

  typedef struct {
    logic [31:0] meth;
    logic [31:0] v;
  } say_t;

  typedef struct {
    logic [31:0] meth;
    logic [31:0] v;
    int          due;
  } echo_t;

  int          checks   = 0;
  int          failures = 0;
  say_t        sb_q[$];
  echo_t       echo_q[$];
  bit          echo_en    = 1'b1;
  bit          corrupt_en = 1'b0;
  int          m3_cnt     = 0;
  int          inj_cnt    = 0;
  int          inj_done   = 0;
  logic [31:0] inj_meth   = '0;
  logic [31:0] inj_v      = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // k-th request of a run with no stalls: method k%NM, index k/NM.
  function automatic say_t exp_say(input int k);
    say_t s;
    s.meth = 32'(k % NM);
    s.v    = (32'(k % NM) << IW) | 32'(k / NM);
    return s;
  endfunction

  task automatic push_says(input int n);
    for (int k = 0; k < n; k++) sb_q.push_back(exp_say(k));
  endtask

  task automatic run_start(input logic [31:0] n);
    @(negedge CLK);
    start = 1'b1;
    total = n;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    for (int i = 0; i < budget && !done; i++) @(negedge CLK);
    chk({name, "_done"}, 32'(done), 32'd1);
  endtask

  // Scoreboard monitor: every accepted request must match the next expected one.
  initial begin : monitor
    say_t e;
    forever begin
      @(negedge CLK);
      #1;
      if (say__ENA && say__RDY && !RST) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected_say actual meth=%0d v=0x%08h expected none", say_meth, say_v);
        end else begin
          e = sb_q.pop_front();
          chk("say_meth", say_meth, e.meth);
          chk("say_v", say_v, e.v);
        end
      end
    end
  end

  // Echo model: returns each accepted request 3 cycles later, with optional
  // corruption of method 3's second response and injected indications.
  initial begin : echo
    int    cyc;
    echo_t e;
    cyc        = 0;
    heard__ENA = 1'b0;
    heard_meth = '0;
    heard_v    = '0;
    forever begin
      @(negedge CLK);
      #1;
      cyc++;
      heard__ENA = 1'b0;
      if (RST) begin
        echo_q.delete();
      end else begin
        if (say__ENA && say__RDY) echo_q.push_back('{say_meth, say_v, cyc + 3});
        if (heard__RDY) begin
          if (inj_cnt != inj_done) begin
            heard__ENA = 1'b1;
            heard_meth = inj_meth;
            heard_v    = inj_v;
            inj_done++;
          end else if (echo_en && echo_q.size() > 0 && echo_q[0].due <= cyc) begin
            e = echo_q.pop_front();
            heard__ENA = 1'b1;
            heard_meth = e.meth;
            heard_v    = e.v;
            if (corrupt_en && e.meth == 32'd3) begin
              m3_cnt++;
              if (m3_cnt == 2) heard_v = 32'h0300_0005;
            end
          end
        end
      end
    end
  end

  initial begin : stim
    RST      = 1'b1;
    start    = 1'b0;
    total    = '0;
    say__RDY = 1'b1;
    repeat (3) @(negedge CLK);

    // Reset state
    chk("rst_say_ena", 32'(say__ENA), 32'd0);
    chk("rst_say_meth", say_meth, 32'd0);
    chk("rst_say_v", say_v, 32'd0);
    chk("rst_heard_rdy", 32'(heard__RDY), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_err_meth", err_meth, 32'd0);
    chk("rst_sent", sent_count, 32'd0);
    chk("rst_recv", recv_count, 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    chk("post_rst_heard_rdy", 32'(heard__RDY), 32'd1);

    // T1: full echoed run of 20
    push_says(20);
    run_start(32'd20);
    chk("t1_busy", 32'(busy), 32'd1);
    wait_done("t1", 300);
    chk("t1_error", 32'(error), 32'd0);
    chk("t1_sent", sent_count, 32'd20);
    chk("t1_recv", recv_count, 32'd20);
    chk("t1_busy_end", 32'(busy), 32'd0);
    chk("t1_sb_left", 32'(sb_q.size()), 32'd0);

    // T2: request held stable while say__RDY is low
    say__RDY = 1'b0;
    push_says(10);
    run_start(32'd10);
    for (int i = 0; i < 5; i++) begin
      chk("t2_ena", 32'(say__ENA), 32'd1);
      chk("t2_meth", say_meth, 32'd0);
      chk("t2_v", say_v, 32'h0000_0000);
      chk("t2_sent", sent_count, 32'd0);
      @(negedge CLK);
    end
    say__RDY = 1'b1;
    wait_done("t2", 300);
    chk("t2_error", 32'(error), 32'd0);
    chk("t2_recv", recv_count, 32'd10);

    // T3: no responses, credit limit stalls issue at NM*MO
    echo_en = 1'b0;
    push_says(20);
    run_start(32'd50);
    repeat (60) @(negedge CLK);
    chk("t3_sent", sent_count, 32'd20);
    chk("t3_ena", 32'(say__ENA), 32'd0);
    chk("t3_busy", 32'(busy), 32'd1);
    chk("t3_recv", recv_count, 32'd0);
    chk("t3_sb_left", 32'(sb_q.size()), 32'd0);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    echo_en = 1'b1;
    @(negedge CLK);

    // total == 0 from IDLE goes straight to DONE
    run_start(32'd0);
    chk("t0_done", 32'(done), 32'd1);
    chk("t0_busy", 32'(busy), 32'd0);

    // T4: corrupted payload on method 3's second response
    corrupt_en = 1'b1;
    m3_cnt     = 0;
    push_says(20);
    run_start(32'd20);
    wait_done("t4", 300);
    chk("t4_error", 32'(error), 32'd1);
    chk("t4_err_meth", err_meth, 32'd3);
    chk("t4_sent", sent_count, 32'd20);
    chk("t4_recv", recv_count, 32'd20);
    corrupt_en = 1'b0;

    // T5a: out-of-range method during RUN; start clears the previous error
    push_says(20);
    run_start(32'd20);
    chk("t5_err_cleared", 32'(error), 32'd0);
    for (int i = 0; i < 100 && sent_count < 32'd5; i++) @(negedge CLK);
    inj_meth = 32'd12;
    inj_v    = 32'h0000_0000;
    inj_cnt++;
    wait_done("t5", 300);
    repeat (10) @(negedge CLK);
    chk("t5_error", 32'(error), 32'd1);
    chk("t5_err_meth", err_meth, 32'd12);
    chk("t5_recv", recv_count, 32'd21);
    chk("t5_sb_left", 32'(sb_q.size()), 32'd0);

    // T5b: indication while IDLE after reset
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    chk("t5b_error_pre", 32'(error), 32'd0);
    inj_meth = 32'd5;
    inj_v    = 32'h0500_0000;
    inj_cnt++;
    repeat (3) @(negedge CLK);
    chk("t5b_error", 32'(error), 32'd1);
    chk("t5b_err_meth", err_meth, 32'd5);
    chk("t5b_recv", recv_count, 32'd1);
    chk("t5b_busy", 32'(busy), 32'd0);

    // total == 0 from IDLE also clears the error
    run_start(32'd0);
    chk("t0b_done", 32'(done), 32'd1);
    chk("t0b_error", 32'(error), 32'd0);
    chk("t0b_recv", recv_count, 32'd0);

    // T6: reset mid-run, then a clean short run
    push_says(20);
    run_start(32'd20);
    for (int i = 0; i < 100 && sent_count != 32'd7; i++) @(negedge CLK);
    chk("t6_sent_reached", sent_count, 32'd7);
    RST = 1'b1;
    @(negedge CLK);
    chk("t6_say_ena", 32'(say__ENA), 32'd0);
    chk("t6_say_meth", say_meth, 32'd0);
    chk("t6_say_v", say_v, 32'd0);
    chk("t6_heard_rdy", 32'(heard__RDY), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_error", 32'(error), 32'd0);
    chk("t6_sent", sent_count, 32'd0);
    chk("t6_recv", recv_count, 32'd0);
    RST = 1'b0;
    sb_q.delete();
    @(negedge CLK);
    push_says(4);
    run_start(32'd4);
    wait_done("t6b", 200);
    chk("t6b_error", 32'(error), 32'd0);
    chk("t6b_sent", sent_count, 32'd4);
    chk("t6b_recv", recv_count, 32'd4);
    chk("t6b_sb_left", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
